// File: rtl/float_conv_arbiter.sv
// rtl/float_conv_arbiter.sv - round-robin sharing of one float_to_fixed converter with in-order result tagging
module float_conv_arbiter #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 8,
  parameter int IWID  = 32,
  parameter int OWID  = 16,
  parameter int FRAC  = 6,
  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IWID-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [IWID-1:0]        cv_tdata,
  output logic                   cv_tvalid,
  input  logic                   cv_tready,
  input  logic [OWID-1:0]        cr_tdata,
  input  logic                   cr_tvalid,
  output logic                   cr_tready,
  output logic [OWID-1:0]        res_data,
  output logic [OWID-FRAC-2:0]   res_int,
  output logic [TAGW-1:0]        res_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          in_flight,
  output logic                   err
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [TAGW-1:0] LAST_REQ = TAGW'(NREQ - 1);

  // arbitration state
  logic [TAGW-1:0] rr_ptr;
  logic            locked;
  logic [TAGW-1:0] lock_idx;

  // tag FIFO state
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [TAGW-1:0] rr_sel;
  logic            rr_found;
  logic [TAGW-1:0] sel;
  logic            full;
  logic            empty;
  logic            issue;
  logic            pop;

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    int idx;
    idx      = 0;
    rr_sel   = rr_ptr;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!rr_found && req_valid[idx]) begin
        rr_sel   = TAGW'(idx);
        rr_found = 1'b1;
      end
    end
  end

  // A stalled grant is held so the converter sees stable data until it accepts
  assign sel       = locked ? lock_idx : rr_sel;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cv_tvalid = (locked | (|req_valid)) & ~full;
  assign cv_tdata  = req_data[int'(sel)*IWID +: IWID];
  assign issue     = cv_tvalid & cv_tready;

  // Only the selected requester sees its ready, and only on an accepted beat
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[sel] = 1'b1;
  end

  // Return path: a beat with no matching tag is swallowed so the converter cannot stall
  assign cr_tready = empty ? 1'b1 : res_ready;
  assign res_valid = cr_tvalid & ~empty;
  assign res_data  = cr_tdata;
  assign res_int   = cr_tdata[OWID-2:FRAC];
  assign res_tag   = tag_mem[rd_ptr];
  assign pop       = cr_tvalid & res_ready & ~empty;
  assign in_flight = count;

  // Grant pointer, lock and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= LAST_REQ;
      locked   <= 1'b0;
      lock_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (issue) begin
        rr_ptr <= sel;
        locked <= 1'b0;
      end else if (cv_tvalid) begin
        locked   <= 1'b1;
        lock_idx <= sel;
      end
      if (cr_tvalid && empty) err <= 1'b1;
    end
  end

  // In-flight tag FIFO, pushed on issue and popped on result acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_float_conv_arbiter.sv
// tb/tb_float_conv_arbiter.sv - scoreboard bench for float_conv_arbiter with a 6-cycle behavioural converter
module tb_float_conv_arbiter;

  localparam int NREQ = 3;
  localparam int DEPTH = 8;
  localparam int IWID = 32;
  localparam int OWID = 16;
  localparam int FRAC = 6;
  localparam int TAGW = 2;
  localparam int CW = 4;
  localparam int LAT = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IWID-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IWID-1:0]      cv_tdata;
  logic                 cv_tvalid;
  logic                 cv_tready = 1'b1;
  logic [OWID-1:0]      cr_tdata;
  logic                 cr_tvalid;
  logic                 cr_tready;
  logic [OWID-1:0]      res_data;
  logic [OWID-FRAC-2:0] res_int;
  logic [TAGW-1:0]      res_tag;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [CW-1:0]        in_flight;
  logic                 err;

  float_conv_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .IWID(IWID), .OWID(OWID), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cv_tdata(cv_tdata), .cv_tvalid(cv_tvalid), .cv_tready(cv_tready),
    .cr_tdata(cr_tdata), .cr_tvalid(cr_tvalid), .cr_tready(cr_tready),
    .res_data(res_data), .res_int(res_int), .res_tag(res_tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .in_flight(in_flight), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAGW-1:0]      tag;
    logic [OWID-1:0]      data;
    logic [OWID-FRAC-2:0] ival;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural converter lookup of hand-computed results (value * 64, rounded)
  function automatic logic [OWID-1:0] conv(input logic [31:0] f);
    case (f)
      32'h3f800000: return 16'h0040;
      32'h40000000: return 16'h0080;
      32'h40400000: return 16'h00C0;
      32'h42d00000: return 16'h1A00;
      32'h43fa4ccd: return 16'h7D26;
      default:      return 16'hDEAD;
    endcase
  endfunction

  // Requester drivers: each holds valid and data until its beats are accepted
  int              rq_cnt [NREQ] = '{default: 0};
  logic [IWID-1:0] rq_dat [NREQ] = '{default: '0};

  initial begin
    logic [NREQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) rq_cnt[i]--;
        req_valid[i] = (rq_cnt[i] > 0);
        req_data[i*IWID +: IWID] = rq_dat[i];
      end
    end
  end

  // Converter model with fixed latency; reset discards everything in flight
  logic [OWID-1:0] cq_d[$];
  int              cq_t[$];
  int              cyc = 0;
  logic            inj = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic rs;
    logic drv_inj;
    drv_inj   = 1'b0;
    cr_tvalid = 1'b0;
    cr_tdata  = '0;
    forever begin
      @(negedge clk);
      rs = rst;
      if (!rs && cv_tvalid && cv_tready) begin
        cq_d.push_back(conv(cv_tdata));
        cq_t.push_back(cyc + LAT);
      end
      if (cr_tvalid && cr_tready && !drv_inj && cq_d.size() > 0) begin
        void'(cq_d.pop_front());
        void'(cq_t.pop_front());
      end
      @(posedge clk);
      #1;
      if (rs) begin
        cq_d.delete();
        cq_t.delete();
      end
      drv_inj   = inj;
      cr_tvalid = drv_inj || (cq_d.size() > 0 && cq_t[0] <= cyc);
      cr_tdata  = drv_inj ? 16'hBEEF : (cq_d.size() > 0 ? cq_d[0] : '0);
    end
  end

  // Result monitor: every accepted result must match the scoreboard head
  exp_t e;
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0d data %0h expected none", res_tag, res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_tag", 32'(res_tag), 32'(e.tag));
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_int", 32'(res_int), 32'(e.ival));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic add_req(input int i, input logic [IWID-1:0] d, input int n);
    rq_dat[i] = d;
    rq_cnt[i] += n;
  endtask

  task automatic expect_res(input int tag, input logic [OWID-1:0] d, input int ival);
    exp_q.push_back('{tag: TAGW'(tag), data: d, ival: (OWID-FRAC-1)'(ival)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int pend;
    for (int k = 0; k < 300; k++) begin
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += rq_cnt[i];
      if (exp_q.size() == 0 && in_flight == 0 && pend == 0) break;
      tick();
    end
    chk({name, "_results_left"}, 32'(exp_q.size()), 0);
    chk({name, "_in_flight_end"}, 32'(in_flight), 0);
  endtask

  task automatic wait_inflight(input string name, input int n);
    for (int k = 0; k < 60; k++) begin
      if (in_flight == CW'(n)) break;
      tick();
    end
    chk({name, "_in_flight"}, 32'(in_flight), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_in_flight", 32'(in_flight), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cv_tvalid", 32'(cv_tvalid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);

    // single requester
    expect_res(0, 16'h1A00, 104);
    add_req(0, 32'h42d00000, 1);
    tick(3);
    chk("single_in_flight", 32'(in_flight), 1);
    drain("single");

    // round robin over three continuously valid requesters
    do_reset();
    for (int r = 0; r < 2; r++) begin
      expect_res(0, 16'h1A00, 104);
      expect_res(1, 16'h7D26, 500);
      expect_res(2, 16'h1A00, 104);
    end
    add_req(0, 32'h42d00000, 2);
    add_req(1, 32'h43fa4ccd, 2);
    add_req(2, 32'h42d00000, 2);
    drain("rr");

    // backpressure lock holds requester 1 while requester 0 arrives
    do_reset();
    cv_tready = 1'b0;
    expect_res(1, 16'h7D26, 500);
    expect_res(0, 16'h1A00, 104);
    add_req(1, 32'h43fa4ccd, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) add_req(0, 32'h42d00000, 1);
      chk("lock_cv_tvalid", 32'(cv_tvalid), 1);
      chk("lock_cv_tdata", cv_tdata, 32'h43fa4ccd);
      chk("lock_req_ready", 32'(req_ready), 0);
    end
    cv_tready = 1'b1;
    #1;
    chk("lock_release_ready", 32'(req_ready), 32'b010);
    drain("lock");

    // full: eight outstanding with results held back, ninth waits
    do_reset();
    res_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: expect_res(0, 16'h0040, 1);
        1: expect_res(1, 16'h0080, 2);
        default: expect_res(2, 16'h00C0, 3);
      endcase
    end
    add_req(0, 32'h3f800000, 3);
    add_req(1, 32'h40000000, 3);
    add_req(2, 32'h40400000, 3);
    wait_inflight("full", 8);
    tick(LAT + 2);
    chk("full_in_flight_hold", 32'(in_flight), 8);
    chk("full_cv_tvalid", 32'(cv_tvalid), 0);
    chk("full_res_valid", 32'(res_valid), 1);
    res_ready = 1'b1;
    #1;
    chk("full_pop_cv_tvalid", 32'(cv_tvalid), 0);
    chk("full_pop_cr_tready", 32'(cr_tready), 1);
    drain("full");

    // error: converter beat with no outstanding tag
    inj = 1'b1;
    tick();
    chk("err_res_valid", 32'(res_valid), 0);
    chk("err_cr_tready", 32'(cr_tready), 1);
    chk("err_not_yet", 32'(err), 0);
    inj = 1'b0;
    tick();
    chk("err_set", 32'(err), 1);
    expect_res(2, 16'h00C0, 3);
    add_req(2, 32'h40400000, 1);
    drain("err_after");
    chk("err_sticky", 32'(err), 1);

    // reset with four conversions outstanding
    res_ready = 1'b0;
    add_req(0, 32'h42d00000, 2);
    add_req(1, 32'h43fa4ccd, 1);
    add_req(2, 32'h42d00000, 1);
    wait_inflight("mid", 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_in_flight", 32'(in_flight), 0);
    chk("mid_rst_cv_tvalid", 32'(cv_tvalid), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    res_ready = 1'b1;
    expect_res(0, 16'h1A00, 104);
    expect_res(1, 16'h7D26, 500);
    add_req(0, 32'h42d00000, 1);
    add_req(1, 32'h43fa4ccd, 1);
    tick();
    chk("mid_rst_first_grant", 32'(req_ready), 32'b001);
    drain("mid");

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
